// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, default widths and requester ids.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way winner select for the data-memory arbiter.
// Pointer side wins ties unless fixed priority is selected.
module dmem_arbiter_rr_pick2
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic any_o,
  output logic gnt_o
);

  always_comb begin
    any_o = req0_i | req1_i;
    gnt_o = REQ_CORE;
    unique case (1'b1)
      (req0_i & req1_i): begin
        gnt_o = (FIXED_PRIO != 0) ? REQ_CORE : ptr_i;
      end
      (req1_i & ~req0_i): begin
        gnt_o = REQ_DMA;
      end
      default: begin
        gnt_o = REQ_CORE;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the 256x8 data memory.
// One access per IDLE->ACCESS->RESP pass; ack and read data land in RESP.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_ea,
  output logic [DATA_W-1:0] mem_result,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                ptr_q, ptr_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                en_q, en_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;

  logic any_req;
  logic win;

  dmem_arbiter_rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0_i(r0_req),
    .req1_i(r1_req),
    .ptr_i (ptr_q),
    .any_o (any_req),
    .gnt_o (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= REQ_CORE;
      ptr_q   <= REQ_CORE;
      ea_q    <= '0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      ea_q    <= ea_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    ea_d    = ea_q;
    wd_d    = wd_q;
    en_d    = en_q;
    rdata_d = rdata_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          gnt_d   = win;
          busy_d  = 1'b1;
          if (win == REQ_DMA) begin
            ea_d = r1_addr;
            wd_d = r1_wdata;
            en_d = r1_we;
          end else begin
            ea_d = r0_addr;
            wd_d = r0_wdata;
            en_d = r0_we;
          end
        end
      end
      ACCESS: begin
        // Sampled after the mid-cycle write, so writes echo their data.
        rdata_d = mem_data;
        ack0_d  = (gnt_q == REQ_CORE);
        ack1_d  = (gnt_q == REQ_DMA);
        en_d    = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        if (FIXED_PRIO == 0) begin
          ptr_d = ~gnt_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign r0_ack     = ack0_q;
  assign r1_ack     = ack1_q;
  assign rdata      = rdata_q;
  assign mem_ea     = ea_q;
  assign mem_result = wd_q;
  assign mem_en     = en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin and fixed-priority
// instances, each with a negedge-write / combinational-read memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       r0_req[2], r0_we[2], r1_req[2], r1_we[2];
  logic [7:0] r0_addr[2], r0_wdata[2], r1_addr[2], r1_wdata[2];
  logic       r0_ack[2], r1_ack[2], mem_en[2], busy[2];
  logic [7:0] rdata[2], mem_ea[2], mem_result[2], mem_data[2];

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem[256];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .r0_req(r0_req[0]), .r0_we(r0_we[0]), .r0_addr(r0_addr[0]),
    .r0_wdata(r0_wdata[0]), .r0_ack(r0_ack[0]),
    .r1_req(r1_req[0]), .r1_we(r1_we[0]), .r1_addr(r1_addr[0]),
    .r1_wdata(r1_wdata[0]), .r1_ack(r1_ack[0]),
    .rdata(rdata[0]), .mem_ea(mem_ea[0]), .mem_result(mem_result[0]),
    .mem_en(mem_en[0]), .mem_data(mem_data[0]), .busy(busy[0])
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .r0_req(r0_req[1]), .r0_we(r0_we[1]), .r0_addr(r0_addr[1]),
    .r0_wdata(r0_wdata[1]), .r0_ack(r0_ack[1]),
    .r1_req(r1_req[1]), .r1_we(r1_we[1]), .r1_addr(r1_addr[1]),
    .r1_wdata(r1_wdata[1]), .r1_ack(r1_ack[1]),
    .rdata(rdata[1]), .mem_ea(mem_ea[1]), .mem_result(mem_result[1]),
    .mem_en(mem_en[1]), .mem_data(mem_data[1]), .busy(busy[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_mem
    logic [7:0] m[256];
    assign mem_data[k] = m[mem_ea[k]];
    always @(negedge clk) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) m[a] <= 8'h00;
      end else if (mem_en[k]) begin
        m[mem_ea[k]] <= mem_result[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int k);
    return {4'h0, r0_ack[k], r1_ack[k], busy[k], mem_en[k],
            rdata[k], mem_ea[k], mem_result[k]};
  endfunction

  // Scoreboard monitor on the round-robin instance
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_ack[0] || r1_ack[0])
        chk("single_ack", 32'(r0_ack[0] & r1_ack[0]), 0);
      if (r0_ack[0]) begin
        chk("q0_nonempty", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) chk("r0_rdata", 32'(rdata[0]), 32'(q0.pop_front()));
      end
      if (r1_ack[0]) begin
        chk("q1_nonempty", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) chk("r1_rdata", 32'(rdata[0]), 32'(q1.pop_front()));
      end
      if (mem_en[0]) chk("en_busy", 32'(busy[0]), 1);
    end
  end

  // One access on the round-robin instance; expectation pushed at issue
  task automatic issue(input bit id, input bit we, input logic [7:0] addr,
                       input logic [7:0] wd, output int lat);
    logic [7:0] exp;
    bit got;
    exp = we ? wd : ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    if (id) q1.push_back(exp);
    else q0.push_back(exp);
    @(posedge clk); #1;
    if (id) begin
      r1_req[0] = 1'b1; r1_we[0] = we; r1_addr[0] = addr; r1_wdata[0] = wd;
    end else begin
      r0_req[0] = 1'b1; r0_we[0] = we; r0_addr[0] = addr; r0_wdata[0] = wd;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (id ? r1_ack[0] : r0_ack[0]) got = 1'b1;
      else lat++;
    end
    chk("ack_timeout", 32'(got), 1);
    chk("other_ack", 32'(id ? r0_ack[0] : r1_ack[0]), 0);
    @(posedge clk); #1;
    if (id) r1_req[0] = 1'b0;
    else r0_req[0] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", 32'(id ? r1_ack[0] : r0_ack[0]), 0);
  endtask

  // Hold requests; drop each side after it has seen n acks
  task automatic run_hold(input int k, input int n0, input int n1,
                          output int ids[6], output int cyc[6], output int n);
    int c0, c1;
    bit d0, d1;
    c0 = 0; c1 = 0; d0 = 0; d1 = 0; n = 0;
    for (int i = 0; i < 6; i++) begin ids[i] = -1; cyc[i] = -1; end
    @(posedge clk); #1;
    r0_req[k] = (n0 > 0);
    r1_req[k] = (n1 > 0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (r0_ack[k]) begin
        if (n < 6) begin ids[n] = 0; cyc[n] = c; end
        n++; c0++; d0 = (c0 == n0);
      end
      if (r1_ack[k]) begin
        if (n < 6) begin ids[n] = 1; cyc[n] = c; end
        n++; c1++; d1 = (c1 == n1);
      end
      @(posedge clk); #1;
      if (d0) begin r0_req[k] = 1'b0; d0 = 0; end
      if (d1) begin r1_req[k] = 1'b0; d1 = 0; end
    end
    r0_req[k] = 1'b0;
    r1_req[k] = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input int ids[6], input int cyc[6],
                         input int n, input int eid[4], input int ecyc[4],
                         input int ne);
    chk({nm, "_count"}, n, ne);
    for (int i = 0; i < ne; i++) begin
      chk({nm, "_id"}, ids[i], eid[i]);
      chk({nm, "_cyc"}, cyc[i], ecyc[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int ids[6];
    int cyc[6];
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r0_req[k] = 0; r0_we[k] = 0; r0_addr[k] = 0; r0_wdata[k] = 0;
      r1_req[k] = 0; r1_we[k] = 0; r1_addr[k] = 0; r1_wdata[k] = 0;
    end
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rr", outs(0), 0);
    chk("reset_fp", outs(1), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // r0 write 0x5A to 0x10 with per-cycle timing
    q0.push_back(8'h5A);
    ref_mem[8'h10] = 8'h5A;
    @(posedge clk); #1;
    r0_req[0] = 1; r0_we[0] = 1; r0_addr[0] = 8'h10; r0_wdata[0] = 8'h5A;
    @(negedge clk);
    chk("t1_c0_en", 32'(mem_en[0]), 0);
    chk("t1_c0_busy", 32'(busy[0]), 0);
    @(negedge clk);
    chk("t1_c1_en", 32'(mem_en[0]), 1);
    chk("t1_c1_ea", 32'(mem_ea[0]), 32'h10);
    chk("t1_c1_wd", 32'(mem_result[0]), 32'h5A);
    chk("t1_c1_busy", 32'(busy[0]), 1);
    chk("t1_c1_ack", 32'(r0_ack[0]), 0);
    @(negedge clk);
    chk("t1_c2_ack", 32'(r0_ack[0]), 1);
    chk("t1_c2_en", 32'(mem_en[0]), 0);
    @(posedge clk); #1;
    r0_req[0] = 0;
    @(negedge clk);
    chk("t1_c3_ack", 32'(r0_ack[0]), 0);
    chk("t1_c3_busy", 32'(busy[0]), 0);
    chk("t1_c3_ea_hold", 32'(mem_ea[0]), 32'h10);

    issue(1, 0, 8'h10, 8'h00, lat);
    chk("lat_r1_rd10", lat, 2);
    issue(0, 1, 8'hFF, 8'h80, lat);
    chk("lat_r0_wrFF", lat, 2);
    issue(1, 0, 8'hFF, 8'h00, lat);
    chk("lat_r1_rdFF", lat, 2);

    // Leave pointer at r0 before the contention run
    issue(0, 1, 8'h01, 8'h11, lat);
    issue(1, 1, 8'h02, 8'h22, lat);
    r0_we[0] = 0; r0_addr[0] = 8'h01;
    r1_we[0] = 0; r1_addr[0] = 8'h02;
    q0.push_back(8'h11); q0.push_back(8'h11);
    q1.push_back(8'h22); q1.push_back(8'h22);
    run_hold(0, 2, 2, ids, cyc, n);
    chk_seq("rr_order", ids, cyc, n, '{0, 1, 0, 1}, '{2, 5, 8, 11}, 4);

    r0_we[1] = 0; r0_addr[1] = 8'h01;
    r1_we[1] = 0; r1_addr[1] = 8'h02;
    run_hold(1, 3, 1, ids, cyc, n);
    chk_seq("fp_order", ids, cyc, n, '{0, 0, 0, 1}, '{2, 5, 8, 11}, 4);

    // r0 keeps req high through its ack cycle
    r0_we[0] = 0; r0_addr[0] = 8'h10;
    q0.push_back(ref_mem[8'h10]); q0.push_back(ref_mem[8'h10]);
    run_hold(0, 2, 0, ids, cyc, n);
    chk_seq("resp_hold", ids, cyc, n, '{0, 0, 0, 0}, '{2, 5, 0, 0}, 2);

    // Reset during the ACCESS cycle of an r1 write
    @(posedge clk); #1;
    r1_req[0] = 1; r1_we[0] = 1; r1_addr[0] = 8'h07; r1_wdata[0] = 8'h33;
    @(negedge clk);
    chk("rst_t_idle_busy", 32'(busy[0]), 0);
    @(posedge clk); #1;
    chk("rst_t_access_en", 32'(mem_en[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r1_req[0] = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    @(negedge clk);
    chk("rst_mid_outs", outs(0), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ack", 32'(r1_ack[0]), 0);
    end
    issue(0, 0, 8'h07, 8'h00, lat);
    chk("lat_after_rst", lat, 2);

    // Random concurrent traffic on disjoint address halves
    fork
      begin
        int l0;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          issue(0, 1'($urandom), {1'b0, 7'($urandom)}, 8'($urandom), l0);
        end
      end
      begin
        int l1;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          issue(1, 1'($urandom), {1'b1, 7'($urandom)}, 8'($urandom), l1);
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the 256x8 data memory, which writes on negedge and reads combinationally.
- Requester 0 is the core load/store stage; requester 1 is the DMA/loader port.
- Accepts one request at a time, drives the memory address/data/enable from registers, and returns a one-cycle ack with captured read data.
- Round-robin by default; fixed priority (r0 wins) is selectable.

Parameters:
- ADDR_W, 8, memory address width (depth 2**ADDR_W)
- DATA_W, 8, data width, signed two's complement
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = r0 always wins ties

Ports:
- clk  in  1  system clock; FSM on posedge, memory writes on the following negedge
- rst  in  1  synchronous, active-high reset
- r0_req  in  1  request, held high until r0_ack is seen
- r0_we  in  1  1 = write, 0 = read; stable while r0_req is high
- r0_addr  in  ADDR_W  address
- r0_wdata  in  DATA_W  write data
- r0_ack  out  1  one-cycle completion pulse
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack  same as r0_*, for requester 1
- rdata  out  DATA_W  shared read result; valid only in a cycle where either ack is high
- mem_ea  out  ADDR_W  memory address (registered)
- mem_result  out  DATA_W  memory write data (registered)
- mem_en  out  1  memory write enable (registered)
- mem_data  in  DATA_W  memory combinational read data
- busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (posedge with rst=1):
  - state=IDLE; all outputs 0 (acks, rdata, mem_ea, mem_result, mem_en, busy).
  - Round-robin pointer = 0, so r0 has priority first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay.
  - Any req: choose winner. If only one requests, it wins. If both request: with FIXED_PRIO=1, r0 wins; otherwise the pointer side wins.
  - At posedge: latch mem_ea=addr, mem_result=wdata, mem_en=we, grant id, busy=1; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_* are stable across the negedge, so a write lands mid-cycle.
  - At posedge: rdata<=mem_data; ack of the granted requester <=1; mem_en<=0; go to RESP.
  - For a write, rdata equals the written value, because the read is post-negedge.
- RESP (exactly one cycle):
  - Ack is high for this cycle; all requests are ignored, because the acked requester may still hold req.
  - At posedge: ack<=0; busy<=0. Pointer flips to the non-granted requester (round-robin mode only). Go to IDLE.
- Latency: request seen in IDLE cycle t gives ack in cycle t+2.
  - Maximum throughput is 1 access per 3 cycles.
  - mem_ea holds its last value in IDLE; mem_en is high only during ACCESS.
- Requester rules:
  - A requester drops req, or presents a new request, on the posedge ending its ack cycle.
  - A req still high in the following IDLE cycle is a new access.
- Simultaneous events:
  - Both requesters in IDLE: one is served, and the loser is served in the next IDLE (round-robin).
  - With FIXED_PRIO=1, r1 starves while r0 requests continuously (accepted behaviour).
- Changing addr/we/wdata while req is high and not yet granted: whatever is present in the granting IDLE cycle is used.
- Reset mid-operation:
  - Returns to IDLE at that posedge; no ack is issued for the aborted access.
  - A write whose negedge coincides with rst high is overridden by the memory's own reset clear.
- Widths are fixed: no arithmetic, no address wrap. The full 0..2**ADDR_W-1 range is legal.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACCESS, RESP}
  - ADDR_W/DATA_W defaults
  - requester id constants REQ_CORE=0, REQ_DMA=1
- One natural sub-module: rr_pick2, the combinational 2-way winner select from req0/req1/pointer/FIXED_PRIO. Everything else lives in the top FSM.

Test Plan:
- Reset then r0 write addr 0x10, data 0x5A:
  - mem_en=1 only in the ACCESS cycle.
  - r0_ack pulses at t+2 with rdata=0x5A.
  - A later r1 read of 0x10 returns 0x5A.
- r0 write 0x80 (-128) to addr 0xFF:
  - r1 read of 0xFF returns rdata=0x80.
  - r1_ack pulses for exactly one cycle and r0_ack stays 0.
- Both requesters hold reads (r0 addr 0x01, r1 addr 0x02) continuously after reset, round-robin:
  - Grant order is r0, r1, r0, r1; acks 3 cycles apart.
- Same stimulus with FIXED_PRIO=1:
  - Only r0 acks while r0_req is high.
  - r1 is acked in the first IDLE after r0 drops req.
- r0 holds req high through its ack cycle (RESP):
  - No regrant during RESP.
  - The next access starts in the following IDLE cycle.
- rst asserted during ACCESS of an r1 write (0x33 to 0x07):
  - No r1_ack; all outputs 0 next cycle; busy=0.
  - After rst releases, a read of 0x07 returns 0x00.
